dac_level_sequencer: RTL and testbench
======================================

// Module: dac_level_sequencer
// PURPOSE
//   Owns the DAC output level and sequences writes to the SPI DAC serializer.
//   BTN_WEST raises the level by STEP, BTN_EAST lowers it, and a change on SW
//   loads SW<<8. Each level change becomes one 32-bit LTC2624 write-and-update
//   command, handed to the serializer over a start/busy handshake.
//   Sits between the board inputs and the SPI DAC shifter in the dac top level.
// PARAMETERS
//   STEP        12'd256  increment/decrement applied per button press
//   INIT_LEVEL  12'd0    level loaded and written to the DAC after reset
//   DAC_ADDR    4'b1111  LTC2624 channel address (1111 = all channels)
// PORTS
//   CLK50MHZ    in   1   system clock, 50 MHz
//   RST         in   1   synchronous reset, active-high
//   BTN_WEST    in   1   "more" button, debounced level, asynchronous to clock
//   BTN_EAST    in   1   "less" button, debounced level, asynchronous to clock
//   SW          in   4   coarse level select: loaded as {SW,8'h00}
//   SPI_BUSY    in   1   serializer busy; high while a word is shifted out
//   SPI_START   out  1   one-cycle pulse; SPI_WORD is valid on that cycle
//   SPI_WORD    out  32  {8'h00, CMD_WRITE_UPDATE, DAC_ADDR, LEVEL, 4'h0}
//   LEVEL       out  12  current committed level (drives LEDs/monitor)
//   BUSY        out  1   high from SPI_START until the serializer completes
// BEHAVIOUR
//   Clocking/reset: one clock. Reset is synchronous and active-high.
//   - Reset values: LEVEL=INIT_LEVEL, SPI_START=0, SPI_WORD=0, BUSY=0,
//     state=IDLE, pending=1 (one initial write). SW snapshot=SW at reset.
//   - RST asserted mid-transfer aborts the sequence. SPI_START stays low. The
//     in-flight serializer word is not tracked.
//   Input conditioning:
//   - Each button passes through a 2-FF synchronizer and a rising-edge
//     detector: one event per press, 3 cycles after the input edge.
//   - SW also passes through a 2-FF synchronizer. A sw_event fires when the
//     synchronized SW differs from the registered snapshot, and the snapshot
//     then updates.
//   Level update (evaluated every cycle, any state):
//   - Priority: sw_event > (more XOR less). more AND less in the same cycle
//     cancel and leave no change.
//   - more: LEVEL = min(LEVEL+STEP, 4095), using a 13-bit sum and saturation.
//   - less: LEVEL = (LEVEL<STEP) ? 0 : LEVEL-STEP.
//   - sw_event: LEVEL = {SW_sync,8'h00}.
//   - Any event sets pending=1, even when saturation leaves LEVEL unchanged.
//   - Events arriving while a write is in flight update LEVEL and set pending.
//     They coalesce: at most one extra write follows, carrying the newest LEVEL.
//   FSM:
//   - IDLE: if pending and !SPI_BUSY, go to START.
//   - START: SPI_START=1 for one cycle; SPI_WORD captures LEVEL; pending=0;
//     BUSY=1; go to WAIT_HI.
//   - WAIT_HI: wait for SPI_BUSY=1, then go to WAIT_LO. After 4 cycles without
//     SPI_BUSY, treat the transfer as done and go to IDLE (tolerates a zero-
//     latency serializer).
//   - WAIT_LO: wait for SPI_BUSY=0, then BUSY=0 and go to IDLE.
//   - Latency: event to SPI_START is 2 cycles when IDLE. SPI_WORD holds its
//     value until the next START.
//   - SPI_START never pulses while SPI_BUSY=1.
// STRUCTURE
//   - Package dac_pkg:
//     - CMD_WRITE_UPDATE=4'b0011 and ADDR_ALL=4'b1111
//     - LEVEL_MAX=12'd4095 and the LEVEL width (12)
//     - FSM state encoding IDLE/START/WAIT_HI/WAIT_LO (2 bits)
//   - Sub-module sync_edge (2-FF synchronizer + rising-edge pulse), one
//     instance per button.
//   - SW sync and change detection, level arithmetic and the FSM stay in this
//     module.
// TESTING
//   - Reset release, SPI_BUSY model 40 cycles -> one SPI_START with
//     SPI_WORD=32'h003F_0000, LEVEL=0, then no further starts.
//   - Two BTN_WEST presses 250 ns wide, 3.8 us apart -> words with
//     LEVEL=12'h100 then 12'h200; BUSY spans each transfer.
//   - BTN_EAST at LEVEL=0 -> LEVEL stays 0 and one write of 32'h003F_0000
//     is issued.
//   - SW=4'h1 held 2 us then restored to 0 -> writes of LEVEL 12'h100, then
//     12'h000.
//   - Three BTN_WEST presses during one 40-cycle transfer, starting from
//     LEVEL 12'hF00 -> LEVEL saturates at 12'hFFF and exactly one follow-up
//     write carries 12'hFFF.
//   - BTN_WEST and BTN_EAST rising in the same cycle -> LEVEL unchanged and
//     no SPI_START. RST pulsed in WAIT_LO -> next cycle IDLE, BUSY=0, then a
//     write of INIT_LEVEL.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared constants, FSM encoding and command-word packing for the DAC level sequencer.
`timescale 1ns / 1ps
package dac_pkg;

  localparam int              LEVEL_W          = 12;
  localparam logic [3:0]      CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0]      ADDR_ALL         = 4'b1111;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX     = 12'd4095;
  localparam int              HI_TIMEOUT       = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } seq_state_e;

  // LTC2624 write-and-update word: 8 don't-care bits, command, address, data, 4 pad bits.
  function automatic logic [31:0] dac_word(input logic [3:0] addr,
                                           input logic [LEVEL_W-1:0] level);
    return {8'h00, CMD_WRITE_UPDATE, addr, level, 4'h0};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
`timescale 1ns / 1ps
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  // Pulse appears three clocks after the asynchronous input edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
      pulse  <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/dac_level_sequencer.sv
// Owns the DAC level, turns button/switch events into level changes and
// issues one LTC2624 write per change (coalescing changes made mid-transfer).
`timescale 1ns / 1ps
module dac_level_sequencer
  import dac_pkg::*;
#(
  parameter logic [LEVEL_W-1:0] STEP       = 12'd256,
  parameter logic [LEVEL_W-1:0] INIT_LEVEL = 12'd0,
  parameter logic [3:0]         DAC_ADDR   = ADDR_ALL
) (
  input  logic               CLK50MHZ,
  input  logic               RST,
  input  logic               BTN_WEST,
  input  logic               BTN_EAST,
  input  logic [3:0]         SW,
  input  logic               SPI_BUSY,
  output logic               SPI_START,
  output logic [31:0]        SPI_WORD,
  output logic [LEVEL_W-1:0] LEVEL,
  output logic               BUSY,
  output seq_state_e         dbg_state
);

  // Handshake: SPI_START is a single-cycle request with SPI_WORD valid on that
  // cycle; it is only raised from IDLE while SPI_BUSY is low. The serializer
  // then raises SPI_BUSY for the shift and drops it when finished. If SPI_BUSY
  // never rises within HI_TIMEOUT cycles the transfer is taken as complete.

  logic more;
  logic less;

  sync_edge u_sync_west (
    .clk   (CLK50MHZ),
    .rst   (RST),
    .din   (BTN_WEST),
    .pulse (more)
  );

  sync_edge u_sync_east (
    .clk   (CLK50MHZ),
    .rst   (RST),
    .din   (BTN_EAST),
    .pulse (less)
  );

  logic [3:0] sw_meta;
  logic [3:0] sw_sync;
  logic [3:0] sw_snap;
  logic       sw_event;

  // Snapshot loads the live switches at reset so a static setting is not an event.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      sw_meta <= SW;
      sw_sync <= SW;
      sw_snap <= SW;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
      if (sw_event) sw_snap <= sw_sync;
    end
  end

  assign sw_event = (sw_sync != sw_snap);

  logic [LEVEL_W:0]   sum;
  logic [LEVEL_W-1:0] level_next;
  logic               level_event;

  always_comb begin
    sum         = {1'b0, LEVEL} + {1'b0, STEP};
    level_next  = LEVEL;
    level_event = 1'b0;
    if (sw_event) begin
      level_next  = {sw_sync, 8'h00};
      level_event = 1'b1;
    end else if (more ^ less) begin
      level_event = 1'b1;
      if (more) level_next = (sum > {1'b0, LEVEL_MAX}) ? LEVEL_MAX : sum[LEVEL_W-1:0];
      else      level_next = (LEVEL < STEP) ? '0 : LEVEL - STEP;
    end
  end

  seq_state_e state_q;
  seq_state_e state_d;
  logic [1:0] hi_cnt_q;
  logic [1:0] hi_cnt_d;
  logic       pending;
  logic       go_start;

  always_comb begin
    state_d  = state_q;
    hi_cnt_d = hi_cnt_q;
    unique case (state_q)
      IDLE:    if (pending && !SPI_BUSY) state_d = START;
      START: begin
        hi_cnt_d = '0;
        state_d  = WAIT_HI;
      end
      WAIT_HI: begin
        if (SPI_BUSY)                           state_d = WAIT_LO;
        else if (hi_cnt_q == 2'(HI_TIMEOUT-1))  state_d = IDLE;
        else                                    hi_cnt_d = hi_cnt_q + 2'd1;
      end
      WAIT_LO: if (!SPI_BUSY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign go_start = (state_q == IDLE) && (state_d == START);

  // The word captures level_next, so an event landing on the launch edge is
  // already carried and need not leave pending set.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q  <= IDLE;
      hi_cnt_q <= '0;
      pending  <= 1'b1;
      LEVEL    <= INIT_LEVEL;
      SPI_WORD <= '0;
    end else begin
      state_q  <= state_d;
      hi_cnt_q <= hi_cnt_d;
      LEVEL    <= level_next;
      if (go_start) begin
        pending  <= 1'b0;
        SPI_WORD <= dac_word(DAC_ADDR, level_next);
      end else if (level_event) begin
        pending  <= 1'b1;
      end
    end
  end

  assign SPI_START = (state_q == START);
  assign BUSY      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dac_level_sequencer.sv
// Directed bench for dac_level_sequencer with a 40-cycle serializer model and
// an expected-word queue checked on every SPI_START.
`timescale 1ns / 1ps
module tb_dac_level_sequencer;
  import dac_pkg::*;

  logic        clk;
  logic        rst;
  logic        btn_west;
  logic        btn_east;
  logic [3:0]  sw;
  logic        spi_busy;
  logic        spi_start;
  logic [31:0] spi_word;
  logic [11:0] level;
  logic        busy;
  seq_state_e  dbg_state;

  dac_level_sequencer dut (
    .CLK50MHZ  (clk),
    .RST       (rst),
    .BTN_WEST  (btn_west),
    .BTN_EAST  (btn_east),
    .SW        (sw),
    .SPI_BUSY  (spi_busy),
    .SPI_START (spi_start),
    .SPI_WORD  (spi_word),
    .LEVEL     (level),
    .BUSY      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int tests_run   = 0;
  int tests_fail  = 0;
  int start_cnt   = 0;
  int span_viol   = 0;
  bit ignore_span = 1'b0;
  bit ser_en      = 1'b1;
  int ser_cnt     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor and serializer model share one negedge process to keep ordering fixed.
  initial begin
    spi_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (spi_busy && !busy && !ignore_span) span_viol++;
      if (spi_start) begin
        start_cnt++;
        check("start_while_spi_busy", 32'(spi_busy), 32'd0);
        check("busy_at_start", 32'(busy), 32'd1);
        check("start_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("spi_word", spi_word, exp_q.pop_front());
      end
      if (ser_cnt > 0) ser_cnt--;
      if (spi_start && ser_en) ser_cnt = 40;
      spi_busy = (ser_cnt != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press_ns(input logic w, input logic e, input int ns);
    btn_west = w;
    btn_east = e;
    #(ns);
    btn_west = 1'b0;
    btn_east = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || busy || spi_busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n >= max_cyc), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s0;
    int n;
    rst      = 1'b1;
    btn_west = 1'b0;
    btn_east = 1'b0;
    sw       = 4'h0;
    repeat (4) @(negedge clk);
    check("rst_level", 32'(level), 32'h000);
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_spi_word", spi_word, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Initial write of INIT_LEVEL after reset release.
    exp_q.push_back(32'h003F_0000);
    rst = 1'b0;
    wait_done("init_write_timeout", 100);
    repeat (50) @(negedge clk);
    check("init_single_start", 32'(start_cnt), 32'd1);
    check("init_level", 32'(level), 32'h000);

    // Two west presses, 3.8 us apart.
    exp_q.push_back(32'h003F_1000);
    exp_q.push_back(32'h003F_2000);
    press_ns(1'b1, 1'b0, 250);
    #3550;
    press_ns(1'b1, 1'b0, 250);
    wait_done("west2_timeout", 200);
    check("west2_level", 32'(level), 32'h200);
    check("west2_starts", 32'(start_cnt), 32'd3);

    // Switch load then restore.
    exp_q.push_back(32'h003F_1000);
    exp_q.push_back(32'h003F_0000);
    sw = 4'h1;
    #2000;
    sw = 4'h0;
    wait_done("sw_timeout", 200);
    check("sw_level", 32'(level), 32'h000);

    // East at zero still writes.
    exp_q.push_back(32'h003F_0000);
    press_ns(1'b0, 1'b1, 250);
    wait_done("east_zero_timeout", 100);
    check("east_zero_level", 32'(level), 32'h000);

    // Saturation: three presses inside the F00 transfer coalesce into one FFF write.
    s0 = start_cnt;
    exp_q.push_back(32'h003F_F000);
    exp_q.push_back(32'h003F_FFF0);
    sw = 4'hF;
    n = 0;
    while (!spi_busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("sat_busy_seen", 32'(spi_busy), 32'd1);
    repeat (3) begin
      btn_west = 1'b1;
      repeat (4) @(negedge clk);
      btn_west = 1'b0;
      repeat (4) @(negedge clk);
    end
    check("sat_level_mid", 32'(level), 32'hFFF);
    wait_done("sat_timeout", 200);
    check("sat_level", 32'(level), 32'hFFF);
    check("sat_starts", 32'(start_cnt - s0), 32'd2);

    // Simultaneous presses cancel.
    s0 = start_cnt;
    press_ns(1'b1, 1'b1, 250);
    repeat (20) @(negedge clk);
    check("cancel_level", 32'(level), 32'hFFF);
    check("cancel_no_start", 32'(start_cnt - s0), 32'd0);

    // East from full scale.
    exp_q.push_back(32'h003F_EFF0);
    press_ns(1'b0, 1'b1, 250);
    wait_done("east_ff_timeout", 100);
    check("east_ff_level", 32'(level), 32'hEFF);
    check("busy_span", 32'(span_viol), 32'd0);

    // Reset while waiting for the serializer to finish.
    exp_q.push_back(32'h003F_FFF0);
    press_ns(1'b1, 1'b0, 250);
    n = 0;
    while (dbg_state != WAIT_LO && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("reach_wait_lo", 32'(dbg_state), 32'(WAIT_LO));
    check("wait_lo_level", 32'(level), 32'hFFF);
    ignore_span = 1'b1;
    exp_q.push_back(32'h003F_0000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_level", 32'(level), 32'h000);
    check("abort_no_start", 32'(spi_start), 32'd0);
    wait_done("abort_rewrite_timeout", 200);
    ignore_span = 1'b0;

    // Serializer that never raises busy: WAIT_HI must time out.
    ser_en = 1'b0;
    exp_q.push_back(32'h003F_1000);
    press_ns(1'b1, 1'b0, 250);
    wait_done("zero_lat_timeout", 40);
    check("zero_lat_level", 32'(level), 32'h100);
    check("zero_lat_state", 32'(dbg_state), 32'(IDLE));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
